// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int unsigned WORD_SIZE_DEF = 8;
    localparam int unsigned N_REQ_DEF     = 4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side write bus and held-register status of the shared register arbiter.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned word_size = WORD_SIZE_DEF,
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned ID_W      = $clog2(N_REQ)
);

    logic [N_REQ-1:0]           req;
    logic [N_REQ-1:0]           lock;
    logic [N_REQ*word_size-1:0] wdata;
    logic [N_REQ-1:0]           ack;
    logic [word_size-1:0]       data_out;
    logic [ID_W-1:0]            owner;
    logic                       locked;
    logic                       updated;

    modport master (
        output req, lock, wdata,
        input  ack, data_out, owner, locked, updated
    );

    modport slave (
        input  req, lock, wdata,
        output ack, data_out, owner, locked, updated
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate so rr_ptr+1 is bit 0, take the lowest set bit,
// rotate the result back.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    logic [N_REQ-1:0] rot;
    int unsigned      start;
    int unsigned      hit;
    int unsigned      abs_idx;

    always_comb begin
        start   = (32'(rr_ptr) + 32'd1) % N_REQ;
        rot     = '0;
        gnt     = '0;
        gnt_idx = '0;
        hit     = N_REQ;
        abs_idx = 0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            rot[j] = req[(start + j) % N_REQ];
        end
        // Scan downward so the lowest set bit wins.
        for (int unsigned j = N_REQ; j > 0; j--) begin
            if (rot[j-1]) hit = j - 1;
        end
        if (hit < N_REQ) begin
            abs_idx      = (start + hit) % N_REQ;
            gnt[abs_idx] = 1'b1;
            gnt_idx      = ID_W'(abs_idx);
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared held register, with per-requester burst lock.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned word_size = WORD_SIZE_DEF,
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned ID_W      = $clog2(N_REQ)
) (
    input logic          clk,
    input logic          rst,
    reg_write_arbiter_if.slave bus
);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      owner_q;
    logic [word_size-1:0] data_q;
    logic                 updated_q;

    logic [N_REQ-1:0]     pick_gnt;
    logic [ID_W-1:0]      pick_idx;
    logic [N_REQ-1:0]     ack;
    logic                 wr_en;
    logic [ID_W-1:0]      wr_idx;
    logic [word_size-1:0] lanes [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            lanes[i] = bus.wdata[i*word_size +: word_size];
        end
    end

    always_comb begin
        state_d = state_q;
        ack     = '0;
        wr_en   = 1'b0;
        wr_idx  = owner_q;
        // Reset masks any grant so nothing looks accepted on a dropped edge.
        if (rst) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (|pick_gnt) begin
                        ack    = pick_gnt;
                        wr_en  = 1'b1;
                        wr_idx = pick_idx;
                        if (bus.lock[pick_idx]) state_d = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (bus.req[owner_q]) begin
                        ack[owner_q] = 1'b1;
                        wr_en        = 1'b1;
                        if (!bus.lock[owner_q]) state_d = ARB_IDLE;
                    end else if (!bus.lock[owner_q]) begin
                        state_d = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= ID_W'(N_REQ - 1);
            owner_q   <= '0;
            data_q    <= '0;
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            updated_q <= wr_en;
            if (wr_en) begin
                data_q   <= lanes[wr_idx];
                owner_q  <= wr_idx;
                rr_ptr_q <= wr_idx;
            end
        end
    end

    assign bus.ack      = ack;
    assign bus.data_out = data_q;
    assign bus.owner    = owner_q;
    assign bus.locked   = (state_q == ARB_LOCKED);
    assign bus.updated  = updated_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (N_REQ=4, word_size=8).
module tb_reg_write_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reg_write_arbiter_if #(.word_size(8), .N_REQ(4), .ID_W(2)) bus ();

    reg_write_arbiter #(
        .word_size (8),
        .N_REQ     (4),
        .ID_W      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change just after a falling edge; checks follow 1 ns later, far from posedge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.lock = 4'b0000;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        next_cycle();
        next_cycle();
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected %b", bus.ack, 4'b0000); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected %h", bus.data_out, 8'h00); end
        n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected %0d", bus.owner, 0); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected %b", bus.locked, 1'b0); end
        n_checks++; if (bus.updated !== 1'b0) begin n_fail++; $display("FAIL reset_updated: got %b expected %b", bus.updated, 1'b0); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ack: got %b expected %b", bus.ack, 4'b0001); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        logic [7:0] exp_data;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            exp_ack  = 4'b0001 << (k % 4);
            exp_data = 8'h10 + 8'((k - 1) % 4);
            n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, bus.ack, exp_ack); end
            n_checks++; if (bus.data_out !== exp_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, bus.data_out, exp_data); end
            n_checks++; if (bus.updated !== 1'b1) begin n_fail++; $display("FAIL rr_updated[%0d]: got %b expected %b", k, bus.updated, 1'b1); end
        end
    endtask

    task automatic test_lock_burst();
        logic [7:0] exp_data;
        // Pointer sits at 3 after the round-robin run, so requester 1 wins first.
        bus.req = 4'b0110;
        for (int t = 0; t < 4; t++) begin
            exp_data = 8'h30 + 8'(t);
            bus.lock = (t < 3) ? 4'b0010 : 4'b0000;
            bus.wdata = {8'hE3, 8'hE2, exp_data, 8'hE0};
            #1;
            n_checks++; if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL lock_ack[%0d]: got %b expected %b", t, bus.ack, 4'b0010); end
            next_cycle();
            n_checks++; if (bus.data_out !== exp_data) begin n_fail++; $display("FAIL lock_data[%0d]: got %h expected %h", t, bus.data_out, exp_data); end
            n_checks++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL lock_owner[%0d]: got %0d expected %0d", t, bus.owner, 1); end
            n_checks++; if (bus.locked !== (t < 3)) begin n_fail++; $display("FAIL lock_locked[%0d]: got %b expected %b", t, bus.locked, (t < 3)); end
        end
        bus.lock = 4'b0100;
        bus.wdata = {8'hE3, 8'h42, 8'hE1, 8'hE0};
        #1;
        n_checks++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL lock_after_ack: got %b expected %b", bus.ack, 4'b0100); end
        next_cycle();
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock2_locked: got %b expected %b", bus.locked, 1'b1); end
        n_checks++; if (bus.owner !== 2'd2) begin n_fail++; $display("FAIL lock2_owner: got %0d expected %0d", bus.owner, 2); end
        n_checks++; if (bus.data_out !== 8'h42) begin n_fail++; $display("FAIL lock2_data: got %h expected %h", bus.data_out, 8'h42); end
    endtask

    task automatic test_lock_hold_abandon();
        bus.req = 4'b0011;
        bus.lock = 4'b0100;
        bus.wdata = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        #1;
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL hold_ack: got %b expected %b", bus.ack, 4'b0000); end
        next_cycle();
        n_checks++; if (bus.data_out !== 8'h42) begin n_fail++; $display("FAIL hold_data: got %h expected %h", bus.data_out, 8'h42); end
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL hold_locked: got %b expected %b", bus.locked, 1'b1); end
        n_checks++; if (bus.updated !== 1'b0) begin n_fail++; $display("FAIL hold_updated: got %b expected %b", bus.updated, 1'b0); end
        bus.lock = 4'b0000;
        #1;
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL abandon_ack: got %b expected %b", bus.ack, 4'b0000); end
        next_cycle();
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL abandon_locked: got %b expected %b", bus.locked, 1'b0); end
        n_checks++; if (bus.data_out !== 8'h42) begin n_fail++; $display("FAIL abandon_data: got %h expected %h", bus.data_out, 8'h42); end
        n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL abandon_next_ack: got %b expected %b", bus.ack, 4'b0001); end
        // Lock requester 0 to set up the reset-mid-burst case.
        bus.lock = 4'b0001;
        bus.wdata = {8'hF3, 8'hF2, 8'hF1, 8'h55};
        next_cycle();
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked: got %b expected %b", bus.locked, 1'b1); end
        n_checks++; if (bus.data_out !== 8'h55) begin n_fail++; $display("FAIL relock_data: got %h expected %h", bus.data_out, 8'h55); end
    endtask

    task automatic test_reset_mid_burst();
        bus.req = 4'b0001;
        bus.lock = 4'b0001;
        bus.wdata = {8'hF3, 8'hF2, 8'hF1, 8'h66};
        #1;
        n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL midrst_pre_ack: got %b expected %b", bus.ack, 4'b0001); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL midrst_ack: got %b expected %b", bus.ack, 4'b0000); end
        next_cycle();
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected %h", bus.data_out, 8'h00); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b expected %b", bus.locked, 1'b0); end
        n_checks++; if (bus.updated !== 1'b0) begin n_fail++; $display("FAIL midrst_updated: got %b expected %b", bus.updated, 1'b0); end
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.lock = 4'b0000;
        #1;
        n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr_ack: got %b expected %b", bus.ack, 4'b0001); end
    endtask

    task automatic test_idle_hold();
        bus.req = 4'b0001;
        bus.lock = 4'b0000;
        bus.wdata = {8'h03, 8'h02, 8'h01, 8'hA5};
        next_cycle();
        n_checks++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL idle_wr_data: got %h expected %h", bus.data_out, 8'hA5); end
        n_checks++; if (bus.updated !== 1'b1) begin n_fail++; $display("FAIL idle_wr_updated: got %b expected %b", bus.updated, 1'b1); end
        bus.req = 4'b0000;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h5A};
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL idle_ack[%0d]: got %b expected %b", k, bus.ack, 4'b0000); end
            next_cycle();
            n_checks++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL idle_data[%0d]: got %h expected %h", k, bus.data_out, 8'hA5); end
            n_checks++; if (bus.updated !== 1'b0) begin n_fail++; $display("FAIL idle_updated[%0d]: got %b expected %b", k, bus.updated, 1'b0); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_lock_hold_abandon();
        test_reset_mid_burst();
        test_idle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
